// File: rtl/counter_updown_param.sv
// Parametrised up/down event counter with modulo wrap, clear, parallel load,
// terminal-count pulse and one-shot mode. Define COUNTER_WRAP_CNT_EN for the wrap_count output.
module counter_updown_param #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             enable,
    input  logic             up_down,
    input  logic             oneshot,
    output logic [WIDTH-1:0] counter_out,
    output logic             tc,
    output logic             done
`ifdef COUNTER_WRAP_CNT_EN
    ,
    output logic [7:0]       wrap_count
`endif
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] term_val;

    // Terminal value follows the direction sampled on this edge.
    assign term_val = up_down ? MAX_VAL : '0;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        if (clear) begin
            count_d = RESET_VAL;
            done_d  = 1'b0;
        end else if (load) begin
            count_d = load_val;
            done_d  = 1'b0;
        end else if (enable && !done_q) begin
            if (count_q == term_val) begin
                tc_d = 1'b1;
                if (oneshot) begin
                    done_d = 1'b1;
                end else begin
                    count_d = up_down ? '0 : MAX_VAL;
                end
            end else if (up_down) begin
                // Only an out-of-range loaded value can reach here at or above MAX_VAL.
                count_d = (count_q >= MAX_VAL) ? '0 : count_q + WIDTH'(1);
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign counter_out = count_q;
    assign tc          = tc_q;
    assign done        = done_q;

`ifdef COUNTER_WRAP_CNT_EN
    logic [7:0] wrap_q, wrap_d;

    always_comb begin
        wrap_d = wrap_q;
        if (clear) begin
            wrap_d = '0;
        end else if (tc_d && (wrap_q != 8'hFF)) begin
            wrap_d = wrap_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap_q <= '0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap_count = wrap_q;
`endif

endmodule
